// File: rtl/piso_shreg.sv
// ---------------------------------------------------------------------------
// piso_shreg
//
// Parallel-in / serial-out shift register with frame control. A parallel word
// is loaded through an active-low request (pl_) while the block is idle, then
// shifted out one bit per clock-enabled edge. A bit counter tracks the frame
// and a one-cycle done pulse marks its end. Serial data arriving on ds fills
// the register from the tail, so after a full frame the register holds the
// received word with the first-received bit at the head.
//
// Parameters:
//   WIDTH      register and frame length in bits (must be >= 2)
//   MSB_FIRST  1: shift toward the MSB, q = sr[WIDTH-1]
//              0: shift toward the LSB, q = sr[0]
//
// Ports:
//   cp    clock, rising edge
//   mr    asynchronous active-high reset
//   ce    shift clock enable (does not gate loading)
//   ds    serial data in, enters the tail on each shift
//   pl_   parallel-load request, active-low, sampled synchronously
//   p     parallel data word
//   q     serial output (head bit of the register)
//   q_    complement of q
//   rdy   high while idle; a load is accepted only then
//   busy  high while a frame is being shifted
//   done  one-cycle end-of-frame pulse
//   pq    captured serial word (zero unless the capture option is built)
//
// Build option:
//   PISO_SHREG_CAPTURE_EN  when defined, a capture register latches the
//                          received word on the edge that raises done.
// ---------------------------------------------------------------------------
module piso_shreg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             cp,
  input  logic             mr,
  input  logic             ce,
  input  logic             ds,
  input  logic             pl_,
  input  logic [WIDTH-1:0] p,
  output logic             q,
  output logic             q_,
  output logic             rdy,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] pq
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_nxt;
  logic [WIDTH-1:0] sr_shifted;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             done_nxt;

  // A one-bit frame makes no sense for the shift slicing below, so refuse to
  // elaborate rather than build something broken.
  if (WIDTH < 2) begin : g_width_check
    $error("piso_shreg: WIDTH must be at least 2");
  end

  // The register moves one place toward the head on every shift; the serial
  // input always enters at the opposite end so that, after a full frame, the
  // first-received bit has travelled all the way to the head.
  always_comb begin
    sr_shifted = sr;
    if (MSB_FIRST) begin
      sr_shifted = {sr[WIDTH-2:0], ds};
    end else begin
      sr_shifted = {ds, sr[WIDTH-1:1]};
    end
  end

  // Next-state logic. In IDLE only a load request matters and ce is
  // deliberately ignored so a word can be parked while the link is stalled.
  // In SHIFT the load request is ignored and nothing moves unless ce is high.
  // The counter starts at WIDTH, so the edge that sees cnt == 1 is the last
  // shift of the frame: it returns to IDLE and raises done on the same edge.
  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!pl_) begin
          sr_nxt    = p;
          cnt_nxt   = CNT_LOAD;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (ce) begin
          sr_nxt  = sr_shifted;
          cnt_nxt = cnt - CNT_LAST;
          if (cnt == CNT_LAST) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, data and counter registers. Reset aborts any frame in progress
  // immediately and without a done pulse, since done is cleared here too.
  always_ff @(posedge cp or posedge mr) begin
    if (mr) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      sr    <= sr_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
    end
  end

`ifdef PISO_SHREG_CAPTURE_EN
  // Capture the post-shift register on the frame's final edge; that value is
  // exactly the WIDTH bits received on ds. It is held until the next frame
  // completes or reset.
  always_ff @(posedge cp or posedge mr) begin
    if (mr) begin
      pq <= '0;
    end else if (done_nxt) begin
      pq <= sr_nxt;
    end
  end
`else
  // Without the capture option the word output is simply tied off.
  assign pq = '0;
`endif

  // Status and serial outputs come straight from registers, so there is no
  // combinational path from any input to any output.
  assign rdy  = (state == IDLE);
  assign busy = (state == SHIFT);
  assign q    = MSB_FIRST ? sr[WIDTH-1] : sr[0];
  assign q_   = ~q;

endmodule

// File: tb/tb_piso_shreg.sv
// ---------------------------------------------------------------------------
// tb_piso_shreg
//
// Directed bench for piso_shreg. Two instances share all inputs: one shifts
// MSB-first, the other LSB-first, both with WIDTH = 8. Each scenario task
// drives its own stimulus and checks the relevant instance's outputs against
// hand-computed values, sampling 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_piso_shreg;

  localparam int W = 8;

  logic         cp;
  logic         mr;
  logic         ce;
  logic         ds;
  logic         pl_;
  logic [W-1:0] p;

  logic         qm, qm_, rdym, busym, donem;
  logic [W-1:0] pqm;
  logic         ql, ql_, rdyl, busyl, donel;
  logic [W-1:0] pql;

  int checks;
  int failures;

  logic [W-1:0] exp_pq_ones;
  logic [W-1:0] exp_pq_alt;

  piso_shreg #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .cp(cp), .mr(mr), .ce(ce), .ds(ds), .pl_(pl_), .p(p),
    .q(qm), .q_(qm_), .rdy(rdym), .busy(busym), .done(donem), .pq(pqm)
  );

  piso_shreg #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .cp(cp), .mr(mr), .ce(ce), .ds(ds), .pl_(pl_), .p(p),
    .q(ql), .q_(ql_), .rdy(rdyl), .busy(busyl), .done(donel), .pq(pql)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    cp = 1'b0;
    forever #5 cp = ~cp;
  end

  // Hard stop in case something goes badly wrong with the sequencing.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to just after the next rising edge.
  task automatic applyStimulus();
    @(posedge cp);
    #1;
  endtask

  task automatic test_reset();
    mr  = 1'b0;
    ce  = 1'b0;
    ds  = 1'b0;
    pl_ = 1'b1;
    p   = '0;
    #3 mr = 1'b1;
    #1;
    checks++; if (qm !== 1'b0)   begin failures++; $display("[TB] FAIL reset_q: got %b expected 0", qm); end
    checks++; if (qm_ !== 1'b1)  begin failures++; $display("[TB] FAIL reset_q_: got %b expected 1", qm_); end
    checks++; if (rdym !== 1'b1) begin failures++; $display("[TB] FAIL reset_rdy: got %b expected 1", rdym); end
    checks++; if (busym !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busym); end
    checks++; if (donem !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", donem); end
    checks++; if (pqm !== 8'h00) begin failures++; $display("[TB] FAIL reset_pq: got %h expected 00", pqm); end
    checks++; if (ql !== 1'b0)   begin failures++; $display("[TB] FAIL reset_lsb_q: got %b expected 0", ql); end
    checks++; if (ql_ !== 1'b1)  begin failures++; $display("[TB] FAIL reset_lsb_q_: got %b expected 1", ql_); end
    applyStimulus();
    mr = 1'b0;
    applyStimulus();
    checks++; if (rdym !== 1'b1) begin failures++; $display("[TB] FAIL reset_idle_rdy: got %b expected 1", rdym); end
  endtask

  task automatic test_msb_first();
    logic [W-1:0] w;
    w   = 8'hA5;
    p   = w;
    pl_ = 1'b0;
    ce  = 1'b1;
    ds  = 1'b1;
    applyStimulus();
    pl_ = 1'b1;
    for (int i = 0; i < W; i++) begin
      checks++; if (qm !== w[W-1-i]) begin failures++; $display("[TB] FAIL msb_q[%0d]: got %b expected %b", i, qm, w[W-1-i]); end
      checks++; if (qm_ !== ~w[W-1-i]) begin failures++; $display("[TB] FAIL msb_q_[%0d]: got %b expected %b", i, qm_, ~w[W-1-i]); end
      checks++; if (donem !== 1'b0) begin failures++; $display("[TB] FAIL msb_done_early[%0d]: got %b expected 0", i, donem); end
      checks++; if (busym !== 1'b1) begin failures++; $display("[TB] FAIL msb_busy[%0d]: got %b expected 1", i, busym); end
      applyStimulus();
    end
    checks++; if (donem !== 1'b1) begin failures++; $display("[TB] FAIL msb_done: got %b expected 1", donem); end
    checks++; if (rdym !== 1'b1)  begin failures++; $display("[TB] FAIL msb_rdy_at_done: got %b expected 1", rdym); end
    checks++; if (busym !== 1'b0) begin failures++; $display("[TB] FAIL msb_busy_at_done: got %b expected 0", busym); end
    checks++; if (pqm !== exp_pq_ones) begin failures++; $display("[TB] FAIL msb_pq: got %h expected %h", pqm, exp_pq_ones); end
    checks++; if (qm !== 1'b1) begin failures++; $display("[TB] FAIL msb_head_after: got %b expected 1", qm); end
    applyStimulus();
    checks++; if (donem !== 1'b0) begin failures++; $display("[TB] FAIL msb_done_width: got %b expected 0", donem); end
    checks++; if (pqm !== exp_pq_ones) begin failures++; $display("[TB] FAIL msb_pq_hold: got %h expected %h", pqm, exp_pq_ones); end
  endtask

  task automatic test_lsb_first();
    logic [W-1:0] w;
    w   = 8'h0F;
    p   = w;
    pl_ = 1'b0;
    ce  = 1'b1;
    ds  = 1'b1;
    applyStimulus();
    pl_ = 1'b1;
    for (int i = 0; i < W; i++) begin
      checks++; if (ql !== w[i]) begin failures++; $display("[TB] FAIL lsb_q[%0d]: got %b expected %b", i, ql, w[i]); end
      checks++; if (donel !== 1'b0) begin failures++; $display("[TB] FAIL lsb_done_early[%0d]: got %b expected 0", i, donel); end
      ds = ((i % 2) == 0) ? 1'b1 : 1'b0;
      applyStimulus();
    end
    checks++; if (donel !== 1'b1) begin failures++; $display("[TB] FAIL lsb_done: got %b expected 1", donel); end
    checks++; if (rdyl !== 1'b1)  begin failures++; $display("[TB] FAIL lsb_rdy: got %b expected 1", rdyl); end
    checks++; if (ql !== 1'b1)    begin failures++; $display("[TB] FAIL lsb_head_after: got %b expected 1", ql); end
    checks++; if (pql !== exp_pq_alt) begin failures++; $display("[TB] FAIL lsb_pq: got %h expected %h", pql, exp_pq_alt); end
    ds = 1'b0;
    applyStimulus();
    checks++; if (donel !== 1'b0) begin failures++; $display("[TB] FAIL lsb_done_width: got %b expected 0", donel); end
    checks++; if (ql !== 1'b1)    begin failures++; $display("[TB] FAIL lsb_head_hold: got %b expected 1", ql); end
  endtask

  task automatic test_clock_enable();
    logic [W-1:0] w;
    w   = 8'h0F;
    p   = w;
    pl_ = 1'b0;
    ce  = 1'b0;
    ds  = 1'b0;
    applyStimulus();
    pl_ = 1'b1;
    checks++; if (busym !== 1'b1) begin failures++; $display("[TB] FAIL ce_load_with_ce_low: got busy=%b expected 1", busym); end
    checks++; if (qm !== w[W-1])  begin failures++; $display("[TB] FAIL ce_first_bit: got %b expected %b", qm, w[W-1]); end
    ce = 1'b1;
    for (int n = 1; n <= 2; n++) begin
      applyStimulus();
      checks++; if (qm !== w[W-1-n]) begin failures++; $display("[TB] FAIL ce_pre_stall_q[%0d]: got %b expected %b", n, qm, w[W-1-n]); end
    end
    ce = 1'b0;
    for (int s = 0; s < 3; s++) begin
      applyStimulus();
      checks++; if (qm !== 1'b0)    begin failures++; $display("[TB] FAIL ce_stall_q[%0d]: got %b expected 0", s, qm); end
      checks++; if (busym !== 1'b1) begin failures++; $display("[TB] FAIL ce_stall_busy[%0d]: got %b expected 1", s, busym); end
      checks++; if (donem !== 1'b0) begin failures++; $display("[TB] FAIL ce_stall_done[%0d]: got %b expected 0", s, donem); end
    end
    ce = 1'b1;
    for (int n = 3; n < W; n++) begin
      applyStimulus();
      checks++; if (qm !== w[W-1-n]) begin failures++; $display("[TB] FAIL ce_post_stall_q[%0d]: got %b expected %b", n, qm, w[W-1-n]); end
      checks++; if (donem !== 1'b0)  begin failures++; $display("[TB] FAIL ce_done_early[%0d]: got %b expected 0", n, donem); end
    end
    applyStimulus();
    checks++; if (donem !== 1'b1) begin failures++; $display("[TB] FAIL ce_done_delayed: got %b expected 1", donem); end
    applyStimulus();
    checks++; if (donem !== 1'b0) begin failures++; $display("[TB] FAIL ce_done_width: got %b expected 0", donem); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w1;
    logic [W-1:0] w2;
    w1  = 8'h81;
    w2  = 8'h3C;
    p   = w1;
    pl_ = 1'b0;
    ce  = 1'b1;
    ds  = 1'b0;
    applyStimulus();
    p = w2;
    for (int i = 0; i < W; i++) begin
      checks++; if (qm !== w1[W-1-i]) begin failures++; $display("[TB] FAIL b2b_first_q[%0d]: got %b expected %b", i, qm, w1[W-1-i]); end
      applyStimulus();
    end
    checks++; if (donem !== 1'b1) begin failures++; $display("[TB] FAIL b2b_first_done: got %b expected 1", donem); end
    checks++; if (rdym !== 1'b1)  begin failures++; $display("[TB] FAIL b2b_first_rdy: got %b expected 1", rdym); end
    applyStimulus();
    pl_ = 1'b1;
    checks++; if (busym !== 1'b1)  begin failures++; $display("[TB] FAIL b2b_second_busy: got %b expected 1", busym); end
    checks++; if (donem !== 1'b0)  begin failures++; $display("[TB] FAIL b2b_second_done_low: got %b expected 0", donem); end
    checks++; if (qm !== w2[W-1])  begin failures++; $display("[TB] FAIL b2b_second_q[0]: got %b expected %b", qm, w2[W-1]); end
    for (int i = 1; i < W; i++) begin
      applyStimulus();
      checks++; if (qm !== w2[W-1-i]) begin failures++; $display("[TB] FAIL b2b_second_q[%0d]: got %b expected %b", i, qm, w2[W-1-i]); end
    end
    applyStimulus();
    checks++; if (donem !== 1'b1) begin failures++; $display("[TB] FAIL b2b_second_done: got %b expected 1", donem); end
    applyStimulus();
    checks++; if (rdym !== 1'b1)  begin failures++; $display("[TB] FAIL b2b_idle_after: got %b expected 1", rdym); end
  endtask

  task automatic test_reset_mid_frame();
    logic [W-1:0] w;
    w   = 8'hF0;
    p   = w;
    pl_ = 1'b0;
    ce  = 1'b1;
    ds  = 1'b1;
    applyStimulus();
    pl_ = 1'b1;
    repeat (4) applyStimulus();
    checks++; if (busym !== 1'b1) begin failures++; $display("[TB] FAIL mid_busy_before: got %b expected 1", busym); end
    checks++; if (qm !== w[W-5])  begin failures++; $display("[TB] FAIL mid_q_before: got %b expected %b", qm, w[W-5]); end
    #3 mr = 1'b1;
    #1;
    checks++; if (qm !== 1'b0)    begin failures++; $display("[TB] FAIL mid_reset_q: got %b expected 0", qm); end
    checks++; if (qm_ !== 1'b1)   begin failures++; $display("[TB] FAIL mid_reset_q_: got %b expected 1", qm_); end
    checks++; if (rdym !== 1'b1)  begin failures++; $display("[TB] FAIL mid_reset_rdy: got %b expected 1", rdym); end
    checks++; if (busym !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_busy: got %b expected 0", busym); end
    checks++; if (donem !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_done: got %b expected 0", donem); end
    checks++; if (pqm !== 8'h00)  begin failures++; $display("[TB] FAIL mid_reset_pq: got %h expected 00", pqm); end
    w   = 8'h01;
    p   = w;
    pl_ = 1'b0;
    ds  = 1'b0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus();
      checks++; if (donem !== 1'b0) begin failures++; $display("[TB] FAIL mid_held_done[%0d]: got %b expected 0", k, donem); end
      checks++; if (busym !== 1'b0) begin failures++; $display("[TB] FAIL mid_held_busy[%0d]: got %b expected 0", k, busym); end
    end
    #3 mr = 1'b0;
    applyStimulus();
    pl_ = 1'b1;
    checks++; if (busym !== 1'b1) begin failures++; $display("[TB] FAIL mid_load_after_release: got %b expected 1", busym); end
    for (int i = 0; i < W; i++) begin
      checks++; if (qm !== w[W-1-i]) begin failures++; $display("[TB] FAIL mid_after_q[%0d]: got %b expected %b", i, qm, w[W-1-i]); end
      checks++; if (donem !== 1'b0)  begin failures++; $display("[TB] FAIL mid_after_done_early[%0d]: got %b expected 0", i, donem); end
      applyStimulus();
    end
    checks++; if (donem !== 1'b1) begin failures++; $display("[TB] FAIL mid_after_done: got %b expected 1", donem); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
`ifdef PISO_SHREG_CAPTURE_EN
    exp_pq_ones = 8'hFF;
    exp_pq_alt  = 8'h55;
`else
    exp_pq_ones = 8'h00;
    exp_pq_alt  = 8'h00;
`endif
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_clock_enable();
    test_back_to_back();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
